dht11_uart_formatter: RTL and testbench
=======================================

Name: dht11_uart_formatter

Overview:
Sits directly downstream of the DHT11 control unit and upstream of the UART TX FIFO. Periodically triggers a sensor read and waits for a completed reading or a timeout. Converts the humidity and temperature integer bytes to a fixed-length ASCII line and pushes it byte-by-byte into the TX FIFO. Also counts failed reads. A checksum failure upstream produces no done pulse, so it surfaces here as a timeout.

Parameters:
PERIOD_TICKS, 200000, tick_10us pulses between the end of one line and the next start (2 s).
TIMEOUT_TICKS, 3000, tick_10us pulses allowed between start and dht_done (30 ms).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
tick_10us  input  1  one-clk pulse every 10 us (shared tick generator)
enable  input  1  level; 1 = run periodic acquisition
dht_done  input  1  from DHT11 control unit; high when a reading is complete and valid
dht_valid  input  1  from DHT11 control unit; checksum-ok flag
dht_data  input  40  [39:32] RH int, [31:24] RH dec, [23:16] T int, [15:8] T dec, [7:0] checksum
dht_start  output  1  one-clk start pulse to DHT11 control unit
fifo_wdata  output  8  ASCII byte to TX FIFO
fifo_push  output  1  write strobe to TX FIFO
fifo_full  input  1  TX FIFO full
busy  output  1  high in any state except IDLE
err_count  output  8  timeouts since reset, saturating at 255

Behaviour:
- Reset values (reset_n low, async): state IDLE; all counters 0; dht_start 0; fifo_push 0; fifo_wdata 0x00; busy 0; err_count 0; captured bytes 0.
- FSM states:
  - IDLE: when enable=1, go to TRIG next clk.
  - TRIG: dht_start=1 for exactly one clk; clear tick counter; go to WAIT_DONE.
  - WAIT_DONE: count tick_10us pulses.
    - dht_done=1 && dht_valid=1: capture RH=dht_data[39:32], T=dht_data[23:16]; set ok=1; go to LOAD.
    - Counter reaches TIMEOUT_TICKS first: ok=0; err_count+1 (saturating); go to LOAD.
    - dht_done and timeout in the same clk: done wins.
  - LOAD: compute digits; char index=0; go to SEND. Lasts one clk.
  - SEND: fifo_push = ~fifo_full (combinational from state and fifo_full); fifo_wdata = char[index]. Each push advances index. The push of the last char goes to GAP. fifo_full=1 stalls with index held; no byte is dropped or duplicated.
  - GAP: count tick_10us up to PERIOD_TICKS, then go to TRIG if enable=1, else IDLE. If enable drops during GAP, go to IDLE immediately.
- Line format (13 bytes): 'H','=',d1,d0,'%',' ','T','=',d1,d0,'C',0x0D,0x0A.
- Digit conversion: tens = v/10, ones = v%10, each + 0x30. Values >99 saturate to "99". Implemented with a combinational or iterative subtractor; adds no more than the LOAD cycle.
- On timeout (ok=0): both digit pairs are "--" (0x2D 0x2D); the rest of the line is unchanged.
- enable dropping during TRIG, WAIT_DONE, LOAD or SEND: the current line completes, then the block goes to IDLE (no truncated lines).
- dht_done outside WAIT_DONE is ignored.
- Latency: dht_done to first fifo_push = 2 clk (capture, LOAD) when fifo_full=0; 13 consecutive pushes when the FIFO never fills.
- reset_n asserted mid-line: immediate abort; no further pushes.

Optional Feature:
DHT_FMT_DECIMAL_EN:
- Defined: each reading carries one decimal digit, e.g. "H=45.0% T=23.1C\r\n" (17 bytes). Decimal digit = dec byte, saturated to 9. On timeout the fields read "--.-".
- Undefined: 13-byte integer-only format; dec bytes are unused.

Test Plan:
- enable=1, dht_done+dht_valid with data 0x2D00170028 after start -> one dht_start pulse; FIFO receives "H=45% T=23C\r\n" (0x48 0x3D 0x34 0x35 0x25 0x20 0x54 0x3D 0x32 0x33 0x43 0x0D 0x0A).
- No dht_done for 3000 ticks -> "H=--% T=--C\r\n" pushed; err_count=1. Repeat 300 times -> err_count stays 255.
- fifo_full held high for 20 clk after the 5th byte -> exactly 13 pushes total, order intact, no pushes while full.
- RH byte 0x7F (127), T byte 0x00 -> "H=99% T=00C\r\n".
- enable dropped mid-SEND -> full 13-byte line, then IDLE with busy=0 and no further dht_start. With PERIOD_TICKS=5 and enable held -> next dht_start exactly 5 ticks after the last push.
- reset_n low during SEND -> fifo_push=0, busy=0, err_count=0 in the same cycle.

Source files
------------

// File: rtl/dht11_uart_formatter.sv
// DHT11 acquisition sequencer: triggers periodic reads and writes one ASCII line per reading to the TX FIFO.
// Optional macro DHT_FMT_DECIMAL_EN adds one decimal digit per field (17-byte line instead of 13).
module dht11_uart_formatter #(
   parameter int PERIOD_TICKS  = 200000,
   parameter int TIMEOUT_TICKS = 3000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_10us,
   input  logic        enable,
   input  logic        dht_done,
   input  logic        dht_valid,
   input  logic [39:0] dht_data,
   output logic        dht_start,
   output logic [7:0]  fifo_wdata,
   output logic        fifo_push,
   input  logic        fifo_full,
   output logic        busy,
   output logic [7:0]  err_count
);
`ifdef DHT_FMT_DECIMAL_EN
   localparam int LINE_LEN = 17;
`else
   localparam int LINE_LEN = 13;
`endif
   localparam int CNT_MAX = (PERIOD_TICKS > TIMEOUT_TICKS) ? PERIOD_TICKS : TIMEOUT_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_TICKS - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [4:0]       LAST_IDX     = 5'(LINE_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TRIG = 3'd1,
      ST_WAIT = 3'd2,
      ST_LOAD = 3'd3,
      ST_SEND = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] tick_cnt_r;
   logic [4:0]       idx_r;
   logic [7:0]       rh_r, t_r, err_r;
   logic             ok_r;
   logic [7:0]       rh_hi_r, rh_lo_r, t_hi_r, t_lo_r;
   logic             dht_start_r, busy_r;
   logic             done_ok_s, timeout_s, clr_cnt_s, push_s;
   logic [7:0]       char_s;
   logic             unused_s;
`ifdef DHT_FMT_DECIMAL_EN
   logic [7:0]       rh_dec_r, t_dec_r, rh_dp_r, t_dp_r;
   assign unused_s = ^dht_data[7:0];
`else
   assign unused_s = ^{dht_data[31:24], dht_data[15:0]};
`endif

   // Binary byte to two ASCII digits, saturating at "99"
   function automatic logic [15:0] to_ascii2(input logic [7:0] v);
      logic [7:0] sat;
      logic [3:0] tens;
      logic [7:0] ones;
      sat  = (v > 8'd99) ? 8'd99 : v;
      tens = 4'd0;
      for (int i = 1; i <= 9; i++) begin
         if (sat >= 8'(10 * i)) tens = 4'(i);
      end
      ones = sat - ({4'h0, tens} * 8'd10);
      return {8'h30 + {4'h0, tens}, 8'h30 + ones};
   endfunction

   // Decimal byte to one ASCII digit, saturating at '9'
   function automatic logic [7:0] to_ascii1(input logic [7:0] v);
      return (v > 8'd9) ? 8'h39 : (8'h30 + v);
   endfunction

   assign done_ok_s  = dht_done && dht_valid;
   assign push_s     = (state_r == ST_SEND) && !fifo_full;
   assign fifo_push  = push_s;
   assign fifo_wdata = (state_r == ST_SEND) ? char_s : 8'h00;
   assign dht_start  = dht_start_r;
   assign busy       = busy_r;
   assign err_count  = err_r;

   // Next-state logic; a done in the timeout cycle takes priority
   always_comb begin
      state_nxt_s = state_r;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_nxt_s = ST_TRIG;
            else        state_nxt_s = ST_IDLE;
         end
         ST_TRIG: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (done_ok_s) begin
               state_nxt_s = ST_LOAD;
            end else if (tick_10us && (tick_cnt_r >= TIMEOUT_LAST)) begin
               timeout_s   = 1'b1;
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_LOAD: state_nxt_s = ST_SEND;
         ST_SEND: begin
            if (push_s && (idx_r == LAST_IDX)) state_nxt_s = ST_GAP;
            else                               state_nxt_s = ST_SEND;
         end
         ST_GAP: begin
            if (!enable)                                           state_nxt_s = ST_IDLE;
            else if (tick_10us && (tick_cnt_r >= PERIOD_LAST))     state_nxt_s = ST_TRIG;
            else                                                   state_nxt_s = ST_GAP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      clr_cnt_s = (state_nxt_s != state_r) || ((state_r != ST_WAIT) && (state_r != ST_GAP));
   end

   // Character selection for the current line position
   always_comb begin
      char_s = 8'h00;
      case (idx_r)
`ifdef DHT_FMT_DECIMAL_EN
         5'd0:    char_s = 8'h48;
         5'd1:    char_s = 8'h3D;
         5'd2:    char_s = rh_hi_r;
         5'd3:    char_s = rh_lo_r;
         5'd4:    char_s = 8'h2E;
         5'd5:    char_s = rh_dp_r;
         5'd6:    char_s = 8'h25;
         5'd7:    char_s = 8'h20;
         5'd8:    char_s = 8'h54;
         5'd9:    char_s = 8'h3D;
         5'd10:   char_s = t_hi_r;
         5'd11:   char_s = t_lo_r;
         5'd12:   char_s = 8'h2E;
         5'd13:   char_s = t_dp_r;
         5'd14:   char_s = 8'h43;
         5'd15:   char_s = 8'h0D;
         5'd16:   char_s = 8'h0A;
`else
         5'd0:    char_s = 8'h48;
         5'd1:    char_s = 8'h3D;
         5'd2:    char_s = rh_hi_r;
         5'd3:    char_s = rh_lo_r;
         5'd4:    char_s = 8'h25;
         5'd5:    char_s = 8'h20;
         5'd6:    char_s = 8'h54;
         5'd7:    char_s = 8'h3D;
         5'd8:    char_s = t_hi_r;
         5'd9:    char_s = t_lo_r;
         5'd10:   char_s = 8'h43;
         5'd11:   char_s = 8'h0D;
         5'd12:   char_s = 8'h0A;
`endif
         default: char_s = 8'h00;
      endcase
   end

   // State register with registered start strobe and busy flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         dht_start_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         dht_start_r <= (state_nxt_s == ST_TRIG);
         busy_r      <= (state_nxt_s != ST_IDLE);
      end
   end

   // Tick counter, reading capture, error counter, digit conversion and line index
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_r <= {CNT_W{1'b0}};
         idx_r      <= 5'd0;
         rh_r       <= 8'h00;
         t_r        <= 8'h00;
         ok_r       <= 1'b0;
         err_r      <= 8'h00;
         rh_hi_r    <= 8'h00;
         rh_lo_r    <= 8'h00;
         t_hi_r     <= 8'h00;
         t_lo_r     <= 8'h00;
`ifdef DHT_FMT_DECIMAL_EN
         rh_dec_r   <= 8'h00;
         t_dec_r    <= 8'h00;
         rh_dp_r    <= 8'h00;
         t_dp_r     <= 8'h00;
`endif
      end else begin
         if (clr_cnt_s)      tick_cnt_r <= {CNT_W{1'b0}};
         else if (tick_10us) tick_cnt_r <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

         if ((state_r == ST_WAIT) && done_ok_s) begin
            rh_r <= dht_data[39:32];
            t_r  <= dht_data[23:16];
            ok_r <= 1'b1;
`ifdef DHT_FMT_DECIMAL_EN
            rh_dec_r <= dht_data[31:24];
            t_dec_r  <= dht_data[15:8];
`endif
         end else if (timeout_s) begin
            ok_r <= 1'b0;
            if (err_r != 8'hFF) err_r <= err_r + 8'd1;
         end

         if (state_r == ST_LOAD) begin
            idx_r <= 5'd0;
            if (ok_r) begin
               {rh_hi_r, rh_lo_r} <= to_ascii2(rh_r);
               {t_hi_r, t_lo_r}   <= to_ascii2(t_r);
`ifdef DHT_FMT_DECIMAL_EN
               rh_dp_r <= to_ascii1(rh_dec_r);
               t_dp_r  <= to_ascii1(t_dec_r);
`endif
            end else begin
               {rh_hi_r, rh_lo_r} <= 16'h2D2D;
               {t_hi_r, t_lo_r}   <= 16'h2D2D;
`ifdef DHT_FMT_DECIMAL_EN
               rh_dp_r <= 8'h2D;
               t_dp_r  <= 8'h2D;
`endif
            end
         end else if (push_s) begin
            idx_r <= (idx_r == LAST_IDX) ? 5'd0 : (idx_r + 5'd1);
         end
      end
   end
endmodule

// File: tb/tb_dht11_uart_formatter.sv
// Scoreboard bench for dht11_uart_formatter: expected line bytes are queued per reading and checked on each push.
module tb_dht11_uart_formatter;
   localparam int PERIOD = 5;
   localparam int TMO    = 4;
`ifdef DHT_FMT_DECIMAL_EN
   localparam int LLEN = 17;
`else
   localparam int LLEN = 13;
`endif

   logic        clk = 1'b0;
   logic        reset_n, tick_10us, enable, dht_done, dht_valid, fifo_full;
   logic [39:0] dht_data;
   logic        dht_start, fifo_push, busy;
   logic [7:0]  fifo_wdata, err_count, exp_b;
   logic [7:0]  exp_q[$];
   int          n_vec = 0, n_err = 0, n_push = 0, n_start = 0;

   always #5 clk = ~clk;

   dht11_uart_formatter #(.PERIOD_TICKS(PERIOD), .TIMEOUT_TICKS(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .tick_10us(tick_10us), .enable(enable),
      .dht_done(dht_done), .dht_valid(dht_valid), .dht_data(dht_data),
      .dht_start(dht_start), .fifo_wdata(fifo_wdata), .fifo_push(fifo_push),
      .fifo_full(fifo_full), .busy(busy), .err_count(err_count)
   );

   // tick generator: one-clock pulse every fourth clock
   initial begin
      tick_10us = 1'b0;
      forever begin
         repeat (3) begin @(negedge clk); tick_10us = 1'b0; end
         @(negedge clk); tick_10us = 1'b1;
      end
   end

   // scoreboard monitor, sampled 2 ns after the falling edge
   initial begin
      forever begin
         @(negedge clk); #2;
         if (dht_start === 1'b1) n_start++;
         if (fifo_full === 1'b1) begin
            n_vec++;
            if (fifo_push !== 1'b0) begin
               n_err++; $display("FAIL push_while_full: fifo_push=%b required 0", fifo_push);
            end
         end
         if (fifo_push === 1'b1) begin
            n_push++; n_vec++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL unexpected_push: got %h required no push", fifo_wdata);
            end else begin
               exp_b = exp_q.pop_front();
               if (fifo_wdata !== exp_b) begin
                  n_err++; $display("FAIL line_byte #%0d: got %h required %h", n_push, fifo_wdata, exp_b);
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] dig2(input logic [7:0] v);
      int s;
      s = (v > 8'd99) ? 99 : int'(v);
      return {8'(48 + s / 10), 8'(48 + s % 10)};
   endfunction

   function automatic logic [7:0] dig1(input logic [7:0] v);
      return (v > 8'd9) ? 8'h39 : 8'(48 + int'(v));
   endfunction

   task automatic expect_line(input bit ok, input logic [39:0] d);
      logic [15:0] h, t;
      logic [7:0]  hd, td;
      h  = ok ? dig2(d[39:32]) : 16'h2D2D;
      t  = ok ? dig2(d[23:16]) : 16'h2D2D;
      hd = ok ? dig1(d[31:24]) : 8'h2D;
      td = ok ? dig1(d[15:8])  : 8'h2D;
      exp_q.push_back(8'h48); exp_q.push_back(8'h3D); exp_q.push_back(h[15:8]); exp_q.push_back(h[7:0]);
`ifdef DHT_FMT_DECIMAL_EN
      exp_q.push_back(8'h2E); exp_q.push_back(hd);
`endif
      exp_q.push_back(8'h25); exp_q.push_back(8'h20); exp_q.push_back(8'h54); exp_q.push_back(8'h3D);
      exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
`ifdef DHT_FMT_DECIMAL_EN
      exp_q.push_back(8'h2E); exp_q.push_back(td);
`endif
      exp_q.push_back(8'h43); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
   endtask

   task automatic wait_start(input int target);
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk); #3;
         if (n_start >= target) break;
      end
      n_vec++;
      if (k == 400) begin n_err++; $display("FAIL wait_start: starts=%0d required %0d", n_start, target); end
   endtask

   task automatic wait_pushes(input int target);
      int k;
      for (k = 0; k < 400; k++) begin
         @(negedge clk); #3;
         if (n_push >= target) break;
      end
      n_vec++;
      if (k == 400) begin n_err++; $display("FAIL wait_pushes: pushes=%0d required %0d", n_push, target); end
   endtask

   task automatic drain_idle();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk); #3;
         if (exp_q.size() == 0 && busy === 1'b0) break;
      end
      n_vec++;
      if (k == 3000) begin n_err++; $display("FAIL drain_idle: queued=%0d busy=%b required 0/0", exp_q.size(), busy); end
   endtask

   task automatic respond(input logic [39:0] d);
      @(negedge clk); dht_done = 1'b1; dht_valid = 1'b1; dht_data = d;
      @(negedge clk); dht_done = 1'b0; dht_valid = 1'b0;
   endtask

   task automatic do_read(input logic [39:0] d);
      int s;
      s = n_start;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      enable = 1'b0;
      expect_line(1'b1, d);
      respond(d);
      drain_idle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; dht_done = 1'b0; dht_valid = 1'b0; fifo_full = 1'b0; dht_data = 40'h0;
      #12;
      n_vec += 5;
      if (dht_start !== 1'b0)   begin n_err++; $display("FAIL reset_start: got %b required 0", dht_start); end
      if (fifo_push !== 1'b0)   begin n_err++; $display("FAIL reset_push: got %b required 0", fifo_push); end
      if (fifo_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h required 00", fifo_wdata); end
      if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
      if (err_count !== 8'h00)  begin n_err++; $display("FAIL reset_err: got %h required 00", err_count); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic_line();
      int s, p;
      s = n_start; p = n_push;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      enable = 1'b0;
      expect_line(1'b1, 40'h2D00170028);
      @(negedge clk); dht_done = 1'b1; dht_valid = 1'b1; dht_data = 40'h2D00170028;
      @(negedge clk); dht_done = 1'b0; dht_valid = 1'b0; #2;
      n_vec++;
      if (fifo_push !== 1'b0) begin n_err++; $display("FAIL latency_load: push=%b required 0", fifo_push); end
      @(negedge clk); #2;
      n_vec++;
      if (fifo_push !== 1'b1 || fifo_wdata !== 8'h48) begin
         n_err++; $display("FAIL latency_first: push=%b data=%h required 1/48", fifo_push, fifo_wdata);
      end
      drain_idle();
      n_vec += 2;
      if (n_start - s !== 1)  begin n_err++; $display("FAIL basic_starts: got %0d required 1", n_start - s); end
      if (n_push - p !== LLEN) begin n_err++; $display("FAIL basic_pushes: got %0d required %0d", n_push - p, LLEN); end
      // done outside WAIT_DONE must be ignored
      p = n_push;
      respond(40'h1111111111);
      repeat (10) @(negedge clk); #3;
      n_vec++;
      if (n_push != p || busy !== 1'b0) begin
         n_err++; $display("FAIL stray_done: pushes=%0d busy=%b required %0d/0", n_push, busy, p);
      end
   endtask

   task automatic test_saturate();
      do_read(40'h7F00000000);
      do_read(40'h6409630C00);
      do_read(40'h0A00090000);
   endtask

   task automatic test_timeout();
      int s;
      s = n_start;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      enable = 1'b0;
      expect_line(1'b0, 40'h0);
      drain_idle();
      n_vec++;
      if (err_count !== 8'd1) begin n_err++; $display("FAIL timeout_err: got %0d required 1", err_count); end
   endtask

   task automatic test_backpressure();
      int s, p;
      s = n_start; p = n_push;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      enable = 1'b0;
      expect_line(1'b1, 40'h38051A0300);
      respond(40'h38051A0300);
      wait_pushes(p + 5);
      @(negedge clk); fifo_full = 1'b1;
      repeat (19) @(negedge clk);
      #3;
      n_vec++;
      if (n_push - p !== 5) begin n_err++; $display("FAIL stall_hold: pushes=%0d required 5", n_push - p); end
      @(negedge clk); fifo_full = 1'b0;
      drain_idle();
      n_vec++;
      if (n_push - p !== LLEN) begin n_err++; $display("FAIL stall_total: got %0d required %0d", n_push - p, LLEN); end
   endtask

   task automatic test_back_to_back();
      int s, k, ticks;
      s = n_start; ticks = 0;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      expect_line(1'b1, 40'h1E00140000);
      respond(40'h1E00140000);
      for (k = 0; k < 400; k++) begin
         @(negedge clk); #3;
         if (exp_q.size() == 0) break;
      end
      for (k = 0; k < 200; k++) begin
         @(negedge clk); #3;
         if (n_start > s + 1) break;
         if (tick_10us === 1'b1) ticks++;
      end
      n_vec++;
      if (ticks !== PERIOD || n_start != s + 2) begin
         n_err++; $display("FAIL period_gap: ticks=%0d starts=%0d required %0d/%0d", ticks, n_start - s, PERIOD, 2);
      end
      enable = 1'b0;
      expect_line(1'b1, 40'h5A00020000);
      respond(40'h5A00020000);
      drain_idle();
   endtask

   task automatic test_enable_drop();
      int s, p;
      s = n_start; p = n_push;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      expect_line(1'b1, 40'h3200190000);
      respond(40'h3200190000);
      wait_pushes(p + 4);
      enable = 1'b0;
      drain_idle();
      repeat (60) @(negedge clk);
      #3;
      n_vec += 2;
      if (n_push - p !== LLEN) begin n_err++; $display("FAIL drop_len: got %0d required %0d", n_push - p, LLEN); end
      if (n_start != s + 1 || busy !== 1'b0) begin
         n_err++; $display("FAIL drop_idle: starts=%0d busy=%b required 1/0", n_start - s, busy);
      end
   endtask

   task automatic test_err_saturation();
      int s;
      s = n_start;
      @(negedge clk); enable = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         wait_start(s + k);
         if (k == 300) enable = 1'b0;
         expect_line(1'b0, 40'h0);
      end
      drain_idle();
      n_vec++;
      if (err_count !== 8'd255) begin n_err++; $display("FAIL err_saturate: got %0d required 255", err_count); end
   endtask

   task automatic test_reset_mid_line();
      int s, p;
      s = n_start; p = n_push;
      @(negedge clk); enable = 1'b1;
      wait_start(s + 1);
      expect_line(1'b1, 40'h2D00170028);
      respond(40'h2D00170028);
      wait_pushes(p + 3);
      @(negedge clk); reset_n = 1'b0; #2;
      n_vec += 3;
      if (fifo_push !== 1'b0)  begin n_err++; $display("FAIL rst_push: got %b required 0", fifo_push); end
      if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
      if (err_count !== 8'h00) begin n_err++; $display("FAIL rst_err: got %0d required 0", err_count); end
      exp_q.delete();
      p = n_push;
      enable = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      #3;
      n_vec++;
      if (n_push != p || n_start != s + 1) begin
         n_err++; $display("FAIL rst_quiet: pushes=%0d starts=%0d required %0d/%0d", n_push, n_start - s, p, 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic_line();
      test_saturate();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_enable_drop();
      test_err_saturation();
      test_reset_mid_line();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
